uart_tx_engine: RTL and testbench

//  Parametrised UART transmitter: buffers words in a small FIFO and serialises them LSB-first on tx.
//  Per-frame runtime configuration: baud divisor, data length (5..DATA_MAX), parity mode, 1/2 stop bits.

---
 rtl/uart_tx_engine.sv | 232 +++++++++++++++++++++++
 tb/tb_uart_tx_engine.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine.sv
// UART transmitter: a small TX FIFO feeds a frame serialiser. The serialiser sends data LSB-first
// and takes its baud divisor, data length, parity mode and stop-bit count from the inputs at each frame start.
module uart_tx_engine #(
    parameter int DATA_MAX   = 8,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [DIV_W-1:0]                   div,
    input  logic [$clog2(DATA_MAX+1)-1:0]      data_bits,
    input  logic [1:0]                         parity_mode,
    input  logic                               stop2,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_MAX-1:0]                in_data,
    input  logic                               cts_n,
    output logic                               tx,
    output logic                               busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
    output logic                               tx_done
);

    localparam int DBW = $clog2(DATA_MAX + 1);
    localparam int LW  = $clog2(FIFO_DEPTH + 1);
    localparam int PW  = $clog2(FIFO_DEPTH);

    localparam logic [LW-1:0]  FULL_LVL = LW'(FIFO_DEPTH);
    localparam logic [DBW-1:0] MIN_BITS = DBW'(5);
    localparam logic [DBW-1:0] MAX_BITS = DBW'(DATA_MAX);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [DATA_MAX-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [LW-1:0]       level;
    logic                push, pop;

    logic cts_meta, cts_sync, cts_ok;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [DBW-1:0]      bit_q, bit_d;
    logic                stop_q, stop_d;
    logic                tx_q, tx_d;
    logic                busy_q;
    logic                shift, tick, can_start, frame_end;

    logic [DATA_MAX-1:0] word_q;
    logic [DBW-1:0]      nbits_q;
    logic [DIV_W-1:0]    div_q;
    logic                par_en_q, par_bit_q, stop2_q;

    logic [DATA_MAX-1:0] head, masked;
    logic [DBW-1:0]      nb;
    logic                par_calc, par_en;

    assign push       = in_valid && in_ready;
    assign in_ready   = (level != FULL_LVL);
    assign fifo_level = level;
    assign head       = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Flops reset to "not clear" so a frame cannot start before cts_n has been sampled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cts_meta <= 1'b1;
            cts_sync <= 1'b1;
        end else begin
            cts_meta <= cts_n;
            cts_sync <= cts_meta;
        end
    end

    assign cts_ok = !cts_sync;

    always_comb begin
        if (data_bits < MIN_BITS)
            nb = MIN_BITS;
        else if (data_bits > MAX_BITS)
            nb = MAX_BITS;
        else
            nb = data_bits;
        masked = '0;
        for (int i = 0; i < DATA_MAX; i++)
            masked[i] = head[i] & (i < int'(nb));
        par_calc = (^masked) ^ (parity_mode == 2'b10);
        par_en   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
    end

    assign tick      = (cnt_q == div_q);
    assign can_start = (level != '0) && cts_ok;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        stop_d    = stop_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        shift     = 1'b0;
        frame_end = 1'b0;
        if (state_q != IDLE)
            cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
        case (state_q)
            IDLE: begin
                tx_d  = 1'b1;
                cnt_d = '0;
                if (can_start) begin
                    pop     = 1'b1;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    bit_d   = '0;
                    tx_d    = word_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_q == nbits_q - DBW'(1)) begin
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                            stop_d  = 1'b0;
                        end
                    end else begin
                        bit_d = bit_q + DBW'(1);
                        shift = 1'b1;
                        tx_d  = word_q[1];
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                    stop_d  = 1'b0;
                end
            end
            STOP: begin
                if (tick) begin
                    if (stop2_q && !stop_q) begin
                        stop_d = 1'b1;
                    end else begin
                        frame_end = 1'b1;
                        // Chain straight into the next frame so queued words go out with no idle gap.
                        if (can_start) begin
                            pop     = 1'b1;
                            state_d = START;
                            tx_d    = 1'b0;
                        end else begin
                            state_d = IDLE;
                            tx_d    = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            stop_q    <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            word_q    <= '0;
            nbits_q   <= MIN_BITS;
            div_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            tx_q    <= tx_d;
            busy_q  <= (state_d != IDLE);
            if (pop) begin
                word_q    <= masked;
                nbits_q   <= nb;
                div_q     <= div;
                par_en_q  <= par_en;
                par_bit_q <= par_calc;
                stop2_q   <= stop2;
            end else if (shift) begin
                word_q <= word_q >> 1;
            end
        end
    end

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign tx_done = frame_end;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine: stimulus queues hand-computed serial frames and a line monitor
// compares tx and tx_done cycle-by-cycle against them.
module tb_uart_tx_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] div;
    logic [3:0]  data_bits;
    logic [1:0]  parity_mode;
    logic        stop2;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        cts_n;
    logic        tx;
    logic        busy;
    logic [2:0]  fifo_level;
    logic        tx_done;

    typedef struct {
        string bits;
        int    period;
        bit    b2b;
        string name;
    } exp_t;

    exp_t sb[$];
    int   vecCount  = 0;
    int   missCount = 0;
    bit   monOn     = 1'b0;

    uart_tx_engine #(.DATA_MAX(8), .DIV_W(16), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .div(div), .data_bits(data_bits), .parity_mode(parity_mode),
        .stop2(stop2), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .cts_n(cts_n), .tx(tx), .busy(busy), .fifo_level(fifo_level), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        vecCount++;
        if (act !== req) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Pushes one word and records the frame the line monitor must see for it.
    task automatic applyStimulus(input logic [7:0] word, input string bits, input int period,
                                 input bit b2b, input string name);
        exp_t e;
        e.bits = bits; e.period = period; e.b2b = b2b; e.name = name;
        sb.push_back(e);
        in_valid = 1'b1;
        in_data  = word;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pushRaw(input logic [7:0] word);
        in_valid = 1'b1;
        in_data  = word;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic waitDone(input string name, input int maxCycles);
        bit found = 1'b0;
        for (int i = 0; i < maxCycles; i++) begin
            @(negedge clk);
            if (tx_done === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput({name, " tx_done seen"}, 32'(found), 32'd1);
        @(negedge clk);
        checkOutput({name, " busy after done"}, 32'(busy), 32'd0);
    endtask

    task automatic waitIdle(input string name, input int maxCycles);
        bit found = 1'b0;
        for (int i = 0; i < maxCycles; i++) begin
            @(negedge clk);
            if (busy === 1'b0 && fifo_level === 3'd0) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput({name, " drained"}, 32'(found), 32'd1);
    endtask

    // Called at the negedge of the first start-bit cycle; walks the whole frame.
    task automatic runFrame();
        exp_t e;
        int   total;
        bit   bad = 1'b0, doneBad = 1'b0;
        int   badCyc = 0;
        logic badVal = 1'b0, badExp = 1'b0;
        logic expb;
        if (sb.size() == 0) begin
            checkOutput("unexpected frame start (tx)", 32'(tx), 32'd1);
            return;
        end
        e = sb.pop_front();
        total = e.bits.len() * e.period;
        for (int c = 0; c < total; c++) begin
            if (c > 0) @(negedge clk);
            expb = (e.bits.getc(c / e.period) == 8'h31);
            if (tx !== expb && !bad) begin
                bad = 1'b1; badCyc = c; badVal = tx; badExp = expb;
            end
            if (tx_done !== (c == total - 1))
                doneBad = 1'b1;
        end
        vecCount++;
        if (bad) begin
            missCount++;
            $display("[TB] FAIL %s serial: cycle %0d tx=%b, required %b", e.name, badCyc, badVal, badExp);
        end
        checkOutput({e.name, " tx_done timing ok"}, 32'(!doneBad), 32'd1);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (monOn && !rst && tx === 1'b0) begin
                runFrame();
                while (sb.size() > 0 && sb[0].b2b) begin
                    @(negedge clk);
                    checkOutput({sb[0].name, " back-to-back start"}, 32'(tx), 32'd0);
                    runFrame();
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit sawFrame;
        rst = 1'b1; cts_n = 1'b0; in_valid = 1'b0; in_data = '0;
        div = 16'd3; data_bits = 4'd8; parity_mode = 2'b00; stop2 = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset tx", 32'(tx), 32'd1);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset tx_done", 32'(tx_done), 32'd0);
        checkOutput("reset fifo_level", 32'(fifo_level), 32'd0);
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        monOn = 1'b1;

        // 8N1, 4-cycle bits, plus start latency
        applyStimulus(8'hA5, "0101001011", 4, 1'b0, "8N1 A5");
        checkOutput("latency tx still idle", 32'(tx), 32'd1);
        @(negedge clk);
        checkOutput("latency tx start", 32'(tx), 32'd0);
        checkOutput("latency busy", 32'(busy), 32'd1);
        waitDone("8N1 A5", 100);

        // 7-bit frames with even then odd parity; bit 7 of the second word must be ignored
        div = 16'd0; data_bits = 4'd7; parity_mode = 2'b01;
        applyStimulus(8'h41, "0100000101", 1, 1'b0, "7E1 41");
        waitDone("7E1 41", 50);
        parity_mode = 2'b10;
        applyStimulus(8'hC1, "0100000111", 1, 1'b0, "7O1 C1");
        waitDone("7O1 C1", 50);

        // data_bits below minimum clamps to 5, two stop bits
        div = 16'd1; data_bits = 4'd3; parity_mode = 2'b00; stop2 = 1'b1;
        applyStimulus(8'h1F, "01111111", 2, 1'b0, "5N2 1F");
        waitDone("5N2 1F", 50);

        // CTS blocks starts; FIFO fills; release gives back-to-back frames
        div = 16'd0; data_bits = 4'd8; stop2 = 1'b0; cts_n = 1'b1;
        repeat (3) @(negedge clk);
        applyStimulus(8'h00, "0000000001", 1, 1'b0, "cts w0");
        applyStimulus(8'hFF, "0111111111", 1, 1'b1, "cts w1");
        applyStimulus(8'h3C, "0001111001", 1, 1'b1, "cts w2");
        applyStimulus(8'h81, "0100000011", 1, 1'b1, "cts w3");
        checkOutput("cts full level", 32'(fifo_level), 32'd4);
        checkOutput("cts full in_ready", 32'(in_ready), 32'd0);
        checkOutput("cts blocked tx", 32'(tx), 32'd1);
        checkOutput("cts blocked busy", 32'(busy), 32'd0);
        pushRaw(8'h55);
        checkOutput("cts 5th push ignored", 32'(fifo_level), 32'd4);
        cts_n = 1'b0;
        @(negedge clk);
        checkOutput("cts release +1", 32'(tx), 32'd1);
        @(negedge clk);
        checkOutput("cts release +2", 32'(tx), 32'd1);
        @(negedge clk);
        checkOutput("cts release +3 start", 32'(tx), 32'd0);
        waitIdle("cts burst", 200);
        checkOutput("cts final level", 32'(fifo_level), 32'd0);

        // divisor change mid-frame applies only to the next frame
        div = 16'd3;
        applyStimulus(8'hA5, "0101001011", 4, 1'b0, "div keep");
        repeat (10) @(negedge clk);
        div = 16'd7;
        applyStimulus(8'h0F, "0111100001", 8, 1'b1, "div new");
        waitIdle("div change", 300);

        // async reset mid-DATA with two words still queued
        monOn = 1'b0;
        div = 16'd3;
        pushRaw(8'hA5);
        pushRaw(8'h5A);
        pushRaw(8'hC3);
        checkOutput("pre-reset queued", 32'(fifo_level), 32'd2);
        repeat (12) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("mid-frame reset tx", 32'(tx), 32'd1);
        checkOutput("mid-frame reset level", 32'(fifo_level), 32'd0);
        checkOutput("mid-frame reset busy", 32'(busy), 32'd0);
        checkOutput("mid-frame reset in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        sawFrame = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0)
                sawFrame = 1'b1;
        end
        checkOutput("no frame after reset", 32'(sawFrame), 32'd0);
        checkOutput("scoreboard empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
